// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide unit (RV32M operation set,
// operand width generalised to XLEN). Multiplies use radix-2 shift-add and
// divides use restoring division, one bit per CALC cycle, followed by a SIGN
// cycle that applies the result sign. Divide-by-zero and signed overflow are
// resolved at accept and finish in a single cycle.
// Optional feature: define MULDIV_FAST_MUL_EN to execute all four multiply
// ops with one combinational 2*XLEN multiplier (single-cycle, no CALC/SIGN).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            kill,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] mcand_q, mcand_d;   // multiplicand, or divisor for divides
  logic [XLEN-1:0] hi_q, hi_d;         // product high half, or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;         // multiplier/product low half, or dividend/quotient
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;       // final result must be negated in SIGN
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Incoming request decode: operand signedness, magnitudes and special cases.
  logic            a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_in_s;
  logic            is_div_s, div_zero_s, div_ovf_s, accept_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;

  assign is_div_s   = op[2];
  assign a_signed_s = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                      (op == OP_DIV) || (op == OP_REM);
  assign b_signed_s = (op == OP_MUL) || (op == OP_MULH) ||
                      (op == OP_DIV) || (op == OP_REM);
  assign a_neg_s    = a_signed_s & a[XLEN-1];
  assign b_neg_s    = b_signed_s & b[XLEN-1];
  assign a_mag_s    = a_neg_s ? (ZERO_X - a) : a;
  assign b_mag_s    = b_neg_s ? (ZERO_X - b) : b;
  // A remainder follows the dividend's sign; everything else is negative when signs differ.
  assign neg_in_s   = (op == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
  assign div_zero_s = is_div_s && (b == ZERO_X);
  assign div_ovf_s  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == ONES_X);
  assign accept_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Per-iteration datapath terms.
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN-1:0]   div_trial_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign div_shift_s = {hi_q, lo_q[XLEN-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
  // Only used when div_ge_s holds, where the difference always fits XLEN bits.
  assign div_trial_s = div_shift_s[XLEN-1:0] - mcand_q;
  assign prod_s      = {hi_q, lo_q};
  assign prod_fix_s  = neg_q ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiplier: sign-extend to 2*XLEN so the low 2*XLEN product bits are exact.
  logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_prod_s;
  logic [XLEN-1:0]   fast_res_s;

  assign fast_a_s    = {{XLEN{a_neg_s}}, a};
  assign fast_b_s    = {{XLEN{b_neg_s}}, b};
  assign fast_prod_s = fast_a_s * fast_b_s;
  assign fast_res_s  = (op == OP_MUL) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
`endif

  // Next-state and datapath update; kill forces IDLE and freezes everything else.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            op_d    = op;
            neg_d   = neg_in_s;
            cnt_d   = CNT_ZERO;
            mcand_d = is_div_s ? b_mag_s : a_mag_s;
            lo_d    = is_div_s ? a_mag_s : b_mag_s;
            hi_d    = ZERO_X;
            if (div_zero_s) begin
              result_d = op[1] ? a : ONES_X;
              state_d  = S_DONE;
            end else if (div_ovf_s) begin
              result_d = op[1] ? ZERO_X : a;
              state_d  = S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div_s) begin
              result_d = fast_res_s;
              state_d  = S_DONE;
            end
`endif
            else begin
              state_d = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + CNT_ONE;
          if (op_q[2]) begin
            if (div_ge_s) begin
              hi_d = div_trial_s;
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_shift_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum_s[XLEN:1];
            lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_SIGN;
          end else begin
            state_d = S_CALC;
          end
        end
        S_SIGN: begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:                       result_d = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011:       result_d = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:               result_d = neg_q ? (ZERO_X - lo_q) : lo_q;
            default:                      result_d = neg_q ? (ZERO_X - hi_q) : hi_q;
          endcase
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they never see start combinationally.
  always_comb begin
    busy_d = (state_d == S_CALC) || (state_d == S_SIGN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset to all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      mcand_q  <= ZERO_X;
      hi_q     <= ZERO_X;
      lo_q     <= ZERO_X;
      result_q <= ZERO_X;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (XLEN = 32)
// against an arithmetic reference model with a countdown timing model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam int SLOW_CYC  = XLEN + 2;  // negedges after accept edge until done is seen
  localparam int SLOW_BUSY = XLEN + 1;
  localparam int MUL_CYC   = FAST_MUL ? 1 : SLOW_CYC;
  localparam int MUL_BUSY  = FAST_MUL ? 0 : SLOW_BUSY;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op = 3'b000;
  logic            kill = 1'b0;
  logic [XLEN-1:0] a = 32'd0;
  logic [XLEN-1:0] b = 32'd0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .kill(kill),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of each op, straight from the instruction definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ps;
    longint unsigned ux, uy, pu;
    int ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ix = $signed(x);
    iy = $signed(y);
    case (o)
      OP_MUL:    begin ps = sx * sy; return ps[31:0]; end
      OP_MULH:   begin ps = sx * sy; return ps[63:32]; end
      OP_MULHSU: begin ps = sx * longint'(uy); return ps[63:32]; end
      OP_MULHU:  begin pu = ux * uy; return pu[63:32]; end
      OP_DIV: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return ix / iy;
      end
      OP_DIVU: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      OP_REM: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return ix % iy;
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  // Ops that complete in the cycle right after acceptance.
  function automatic bit quick(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 32'd0) return 1'b1;
    if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
    return (!o[2]) && FAST_MUL;
  endfunction

  // Reference timing: a countdown of remaining busy cycles, plus the held result.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;

  always @(posedge clk) begin
    logic [31:0] r;
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
    end else if (kill) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      r = ref_res(op, a, b);
      if (quick(op, a, b)) begin
        m_res  <= r;
        m_done <= 1'b1;
      end else begin
        m_pend <= r;
        m_left <= XLEN + 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("result", result, m_res);
    end
  end

  // Called at a negedge: presents one start cycle; returns at the first negedge after acceptance.
  task automatic drive_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; checks result, done cycle and number of busy cycles.
  task automatic wait_done(input string nm, input logic [31:0] exp_res, input int exp_cyc, input int exp_busy);
    int n;
    int nb;
    n = 1;
    nb = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_cycle"}, n, exp_cyc);
    chk({nm, "_busycnt"}, nb, exp_busy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);

    // Pin the reference model to hand-computed values.
    chk("model_mul", ref_res(OP_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhsu", ref_res(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model_div", ref_res(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem", ref_res(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    // Multiplies.
    drive_start(OP_MUL, 32'd7, 32'hFFFF_FFFD);             wait_done("mul", 32'hFFFF_FFEB, MUL_CYC, MUL_BUSY);
    drive_start(OP_MULH, 32'h8000_0000, 32'h8000_0000);    wait_done("mulh", 32'h4000_0000, MUL_CYC, MUL_BUSY);
    drive_start(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_done("mulhu", 32'hFFFF_FFFE, MUL_CYC, MUL_BUSY);
    drive_start(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done("mulhsu", 32'hFFFF_FFFF, MUL_CYC, MUL_BUSY);

    // Divides.
    drive_start(OP_DIV, 32'hFFFF_FFF9, 32'd2);   wait_done("div", 32'hFFFF_FFFD, SLOW_CYC, SLOW_BUSY);
    drive_start(OP_REM, 32'hFFFF_FFF9, 32'd2);   wait_done("rem", 32'hFFFF_FFFF, SLOW_CYC, SLOW_BUSY);
    drive_start(OP_DIVU, 32'd100, 32'd7);        wait_done("divu", 32'd14, SLOW_CYC, SLOW_BUSY);
    drive_start(OP_REMU, 32'd100, 32'd7);        wait_done("remu", 32'd2, SLOW_CYC, SLOW_BUSY);

    // Special cases.
    drive_start(OP_DIV, 32'd5, 32'd0);                   wait_done("div0", 32'hFFFF_FFFF, 1, 0);
    drive_start(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("removf", 32'd0, 1, 0);
    drive_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("divovf", 32'h8000_0000, 1, 0);
    drive_start(OP_REMU, 32'd5, 32'd0);                  wait_done("remu0", 32'd5, 1, 0);

    // Start while busy is ignored; kill aborts without done and keeps result.
    drive_start(OP_DIV, 32'd100, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("kill_no_done", {31'd0, seen}, 32'd0);
    chk("kill_result", result, 32'd5);
    drive_start(OP_DIVU, 32'd9, 32'd3);          wait_done("divu_after_kill", 32'd3, SLOW_CYC, SLOW_BUSY);

    // Back-to-back: MUL start presented in the DIV done cycle.
    drive_start(OP_DIV, 32'd1000, 32'hFFFF_FFF6);  wait_done("b2b_div", 32'hFFFF_FF9C, SLOW_CYC, SLOW_BUSY);
    drive_start(OP_MUL, 32'd12, 32'd13);           wait_done("b2b_mul", 32'd156, MUL_CYC, MUL_BUSY);

    // Reset mid-CALC, then a start in the first cycle after reset.
    drive_start(OP_DIVU, 32'd77, 32'd5);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    drive_start(OP_DIVU, 32'd100, 32'd7);          wait_done("after_rst", 32'd14, SLOW_CYC, SLOW_BUSY);

    // Randomized traffic with special-value operands, kills and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 5))
          0:       v = 32'd0;
          1:       v = 32'h8000_0000;
          2:       v = 32'hFFFF_FFFF;
          3:       v = 32'($urandom_range(0, 20));
          default: v = $urandom;
        endcase
        if (k == 0) a = v; else b = v;
      end
      kill = ($urandom_range(0, 59) == 0);
      rst  = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    rst   = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
